// File: rtl/power_gate_sequencer_if.sv
// Handshake bundle between the power-gate sequencer, the switchable domain
// and the power switch. The sequencer sits on the master side.
interface power_gate_sequencer_if;

    logic       sleep_req;
    logic       wake_req;
    logic       pwr_ack;
    logic       err_clr;
    logic       save;
    logic       restore;
    logic       iso_en;
    logic       pwr_en;
    logic       err;
    logic [2:0] state_o;

    modport master (
        input  sleep_req,
        input  wake_req,
        input  pwr_ack,
        input  err_clr,
        output save,
        output restore,
        output iso_en,
        output pwr_en,
        output err,
        output state_o
    );

    modport slave (
        output sleep_req,
        output wake_req,
        output pwr_ack,
        output err_clr,
        input  save,
        input  restore,
        input  iso_en,
        input  pwr_en,
        input  err,
        input  state_o
    );

endinterface

// File: rtl/power_gate_sequencer.sv
// Power-gate sequencer for one switchable domain: save, isolate, power off on
// sleep; power on, restore, de-isolate on wake. Moore outputs, sticky ack-timeout error.
module power_gate_sequencer #(
    parameter int ISO_CYC     = 2,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    power_gate_sequencer_if.master        pg
);

    localparam int MAX_CYC = (ISO_CYC > ACK_TIMEOUT) ? ISO_CYC : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_CYC - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_ON       = 3'd0,
        ST_SAVE     = 3'd1,
        ST_ISOLATE  = 3'd2,
        ST_PWR_DOWN = 3'd3,
        ST_OFF      = 3'd4,
        ST_PWR_UP   = 3'd5,
        ST_RESTORE  = 3'd6,
        ST_DEISO    = 3'd7
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             timeout;
    logic             counting;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ON;
        end else begin
            state_q <= state_d;
        end
    end

    // An ack arriving in the timeout cycle takes the normal path, so the
    // ack test is placed ahead of the timeout test in both handshake states.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            ST_ON: begin
                if (pg.sleep_req) state_d = ST_SAVE;
            end
            ST_SAVE: begin
                state_d = ST_ISOLATE;
            end
            ST_ISOLATE: begin
                if (cnt_q == ISO_LAST) state_d = ST_PWR_DOWN;
            end
            ST_PWR_DOWN: begin
                if (!pg.pwr_ack) begin
                    state_d = ST_OFF;
                end else if (cnt_q == ACK_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_PWR_UP;
                end
            end
            ST_OFF: begin
                if (pg.wake_req) state_d = ST_PWR_UP;
            end
            ST_PWR_UP: begin
                if (pg.pwr_ack) begin
                    state_d = ST_RESTORE;
                end else if (cnt_q == ACK_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_OFF;
                end
            end
            ST_RESTORE: begin
                state_d = ST_DEISO;
            end
            ST_DEISO: begin
                if (cnt_q == ISO_LAST) state_d = ST_ON;
            end
            default: begin
                state_d = ST_ON;
            end
        endcase
    end

    always_comb begin
        counting = (state_q == ST_ISOLATE)  || (state_q == ST_PWR_DOWN) ||
                   (state_q == ST_PWR_UP)   || (state_q == ST_DEISO);
    end

    // Dwell counter restarts on every state change, so each timed state
    // always begins counting from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (counting) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A timeout in the same cycle as err_clr must leave the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end else if (pg.err_clr) begin
            err_q <= 1'b0;
        end
    end

    always_comb begin
        pg.save    = 1'b0;
        pg.restore = 1'b0;
        pg.iso_en  = 1'b1;
        pg.pwr_en  = 1'b1;
        case (state_q)
            ST_ON: begin
                pg.iso_en = 1'b0;
            end
            ST_SAVE: begin
                pg.iso_en = 1'b0;
                pg.save   = 1'b1;
            end
            ST_PWR_DOWN, ST_OFF: begin
                pg.pwr_en = 1'b0;
            end
            ST_RESTORE: begin
                pg.restore = 1'b1;
            end
            default: begin
                pg.iso_en = 1'b1;
            end
        endcase
    end

    assign pg.err     = err_q;
    assign pg.state_o = state_q;

    a_save_restore_exclusive : assert property (
        @(posedge clk) disable iff (rst) !(pg.save && pg.restore));

    a_restore_powered_isolated : assert property (
        @(posedge clk) disable iff (rst) pg.restore |-> (pg.pwr_en && pg.iso_en));

    a_save_single_pulse : assert property (
        @(posedge clk) disable iff (rst) pg.save |=> !pg.save);

    a_restore_single_pulse : assert property (
        @(posedge clk) disable iff (rst) pg.restore |=> !pg.restore);

endmodule

// File: tb/tb_power_gate_sequencer.sv
// Directed bench for power_gate_sequencer: a per-cycle vector table for the
// sleep/wake round trip plus hand-built sequences for the timeout corners.
module tb_power_gate_sequencer;

    logic clk;
    logic rst;
    int   check_count;
    int   pass_count;

    typedef struct packed {
        logic       rst;
        logic       sleep_req;
        logic       wake_req;
        logic       pwr_ack;
        logic       err_clr;
        logic [2:0] exp_state;
        logic       exp_save;
        logic       exp_restore;
        logic       exp_iso;
        logic       exp_pwr;
        logic       exp_err;
    } vec_t;

    localparam int NUM_VECS = 23;

    vec_t       vecs [NUM_VECS];
    logic [2:0] down_exp [16];

    power_gate_sequencer_if pg_if ();

    power_gate_sequencer #(
        .ISO_CYC     (2),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pg  (pg_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are held across one rising edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic r, input logic s, input logic w,
                                 input logic a, input logic c);
        rst             = r;
        pg_if.sleep_req = s;
        pg_if.wake_req  = w;
        pg_if.pwr_ack   = a;
        pg_if.err_clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] act,
                               input logic [2:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [2:0] st, input logic sv,
                            input logic rs, input logic iso, input logic pw,
                            input logic er);
        checkOutput({tag, "_state"},   pg_if.state_o,           st);
        checkOutput({tag, "_save"},    {2'b00, pg_if.save},     {2'b00, sv});
        checkOutput({tag, "_restore"}, {2'b00, pg_if.restore},  {2'b00, rs});
        checkOutput({tag, "_iso_en"},  {2'b00, pg_if.iso_en},   {2'b00, iso});
        checkOutput({tag, "_pwr_en"},  {2'b00, pg_if.pwr_en},   {2'b00, pw});
        checkOutput({tag, "_err"},     {2'b00, pg_if.err},      {2'b00, er});
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;

        // rst sleep wake ack clr | state save restore iso pwr err
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // States seen on cycles 1..16 after sleep_req with pwr_ack stuck high.
        down_exp = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3,
                     3'd3, 3'd3, 3'd3, 3'd5, 3'd6, 3'd7, 3'd7, 3'd0};

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkAll("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].sleep_req, vecs[i].wake_req,
                          vecs[i].pwr_ack, vecs[i].err_clr);
            checkAll($sformatf("row%0d", i), vecs[i].exp_state, vecs[i].exp_save,
                     vecs[i].exp_restore, vecs[i].exp_iso, vecs[i].exp_pwr,
                     vecs[i].exp_err);
        end

        $display("[TB] power-down timeout with pwr_ack stuck high");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("down_to_cyc1_state", pg_if.state_o, down_exp[0]);
        for (int k = 1; k < 16; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("down_to_cyc%0d_state", k + 1), pg_if.state_o, down_exp[k]);
            checkOutput($sformatf("down_to_cyc%0d_err", k + 1),
                        {2'b00, pg_if.err}, {2'b00, (k >= 11)});
            checkOutput($sformatf("down_to_cyc%0d_restore", k + 1),
                        {2'b00, pg_if.restore}, {2'b00, (k == 12)});
            checkOutput($sformatf("down_to_cyc%0d_pwr_en", k + 1),
                        {2'b00, pg_if.pwr_en}, {2'b00, !(k >= 3 && k <= 10)});
        end

        $display("[TB] ack arriving in the timeout cycle");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_after_down_to_err", {2'b00, pg_if.err}, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("ack_edge_last_pd_state", pg_if.state_o, 3'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ack_edge_state", pg_if.state_o, 3'd4);
        checkOutput("ack_edge_err", {2'b00, pg_if.err}, 3'd0);

        $display("[TB] power-up timeout with pwr_ack stuck low");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("up_to_last_pu_state", pg_if.state_o, 3'd5);
        checkOutput("up_to_last_pu_err", {2'b00, pg_if.err}, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("up_to_state", pg_if.state_o, 3'd4);
        checkOutput("up_to_pwr_en", {2'b00, pg_if.pwr_en}, 3'd0);
        checkOutput("up_to_err_beats_clr", {2'b00, pg_if.err}, 3'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("err_clr_state", pg_if.state_o, 3'd4);
        checkOutput("err_clr_err", {2'b00, pg_if.err}, 3'd0);

        $display("[TB] retry wake with good ack");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("retry_pu_state", pg_if.state_o, 3'd5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("retry_restore_state", pg_if.state_o, 3'd6);
        checkOutput("retry_restore_pulse", {2'b00, pg_if.restore}, 3'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkAll("retry_done", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
